// File: rtl/reg_bank_if.sv
//------------------------------------------------------------------------------
// Module      : reg_bank_if
// Description : Write/modify and bus-read signal bundle for reg_bank.
// Revision    : 1.0 - initial release
//------------------------------------------------------------------------------
`default_nettype none

interface reg_bank_if #(
  parameter int WIDTH  = 8,
  parameter int ADDR_W = 2
);
  logic              load_n;
  logic [2:0]        op;
  logic [ADDR_W-1:0] wr_addr;
  logic [WIDTH-1:0]  reg_in;
  logic              enable_n;
  logic [ADDR_W-1:0] rd_addr;
  logic [WIDTH-1:0]  reg_out;
  logic              out_en;
  logic              carry;
  logic              zero;

  modport master (
    output load_n, op, wr_addr, reg_in, enable_n, rd_addr,
    input  reg_out, out_en, carry, zero
  );

  modport slave (
    input  load_n, op, wr_addr, reg_in, enable_n, rd_addr,
    output reg_out, out_en, carry, zero
  );
endinterface

`default_nettype wire

// File: rtl/reg_bank.sv
//------------------------------------------------------------------------------
// Module      : reg_bank
// Description : DEPTH x WIDTH register bank with load/inc/dec/clr write port,
//               carry/zero flags and a registered, zero-when-idle bus read port.
//               Optional SHL/SHR ops enabled by macro REG_BANK_SHIFT_EN.
// Revision    : 1.0 - initial release
//------------------------------------------------------------------------------
`default_nettype none

module reg_bank #(
  parameter int WIDTH = 8,
  parameter int DEPTH = 4
) (
  input  wire logic   clk,
  input  wire logic   rst_n,
  reg_bank_if.slave   bus
);
  localparam int ADDR_W = $clog2(DEPTH);

  localparam logic [2:0] c_OP_LOAD = 3'b000;
  localparam logic [2:0] c_OP_INC  = 3'b001;
  localparam logic [2:0] c_OP_DEC  = 3'b010;
  localparam logic [2:0] c_OP_CLR  = 3'b011;
`ifdef REG_BANK_SHIFT_EN
  localparam logic [2:0] c_OP_SHL  = 3'b100;
  localparam logic [2:0] c_OP_SHR  = 3'b101;
`endif

  logic [WIDTH-1:0] r_bank [DEPTH];
  logic [WIDTH-1:0] r_reg_out;
  logic             r_out_en;
  logic             r_carry;
  logic             r_zero;

  logic [DEPTH-1:0] w_wr_sel;
  logic [DEPTH-1:0] w_rd_sel;
  logic [WIDTH-1:0] w_old;
  logic [WIDTH-1:0] w_rd_data;
  logic [WIDTH-1:0] w_result;
  logic [WIDTH:0]   w_sum;
  logic             w_carry;
  logic             w_exec;
  logic             w_commit;

  // One-hot address decode; out-of-range addresses select nothing.
  for (genvar gi = 0; gi < DEPTH; gi++) begin : g_sel
    assign w_wr_sel[gi] = (bus.wr_addr == ADDR_W'(gi));
    assign w_rd_sel[gi] = (bus.rd_addr == ADDR_W'(gi));
  end

  always_comb begin
    w_old     = '0;
    w_rd_data = '0;
    for (int i = 0; i < DEPTH; i++) begin
      if (w_wr_sel[i]) w_old     = r_bank[i];
      if (w_rd_sel[i]) w_rd_data = r_bank[i];
    end
  end

  always_comb begin
    w_exec   = 1'b1;
    w_result = w_old;
    w_carry  = 1'b0;
    w_sum    = {1'b0, w_old} + (WIDTH+1)'(1);
    case (bus.op)
      c_OP_LOAD: w_result = bus.reg_in;
      c_OP_INC: begin
        w_result = w_sum[WIDTH-1:0];
        w_carry  = w_sum[WIDTH];
      end
      c_OP_DEC: begin
        w_result = w_old - WIDTH'(1);
        w_carry  = (w_old == '0);
      end
      c_OP_CLR:  w_result = '0;
`ifdef REG_BANK_SHIFT_EN
      c_OP_SHL: begin
        w_result = {w_old[WIDTH-2:0], 1'b0};
        w_carry  = w_old[WIDTH-1];
      end
      c_OP_SHR: begin
        w_result = {1'b0, w_old[WIDTH-1:1]};
        w_carry  = w_old[0];
      end
`endif
      default:   w_exec = 1'b0;
    endcase
  end

  assign w_commit = ~bus.load_n & (|w_wr_sel) & w_exec;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < DEPTH; i++) r_bank[i] <= '0;
    end else begin
      for (int i = 0; i < DEPTH; i++) begin
        if (w_commit && w_wr_sel[i]) r_bank[i] <= w_result;
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_carry <= 1'b0;
      r_zero  <= 1'b0;
    end else if (w_commit) begin
      r_carry <= w_carry;
      r_zero  <= (w_result == '0);
    end
  end

  // Read samples the pre-write bank, giving read-before-write on collisions.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_reg_out <= '0;
      r_out_en  <= 1'b0;
    end else begin
      r_reg_out <= bus.enable_n ? '0 : w_rd_data;
      r_out_en  <= ~bus.enable_n;
    end
  end

  assign bus.reg_out = r_reg_out;
  assign bus.out_en  = r_out_en;
  assign bus.carry   = r_carry;
  assign bus.zero    = r_zero;
endmodule

`default_nettype wire
